seg_mux_driver: RTL and testbench

Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display. It scans NUM_DIGITS hex nibbles onto one shared segment bus, asserting one digit enable at a time. A programmable dead-time separates digits to suppress ghosting, and per-digit blanking and decimal points are supported. It sits between the top level (HSOSC-derived clock, user inputs) and the display pins, and replaces the fixed two-digit scanner.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seven_seg_decoder.sv | 13 +
 rtl/seg_mux_driver.sv | 145 ++++++++++++++
 tb/tb_seg_mux_driver.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// Glyph patterns are active-high, bit order {a,b,c,d,e,f,g}.
package seg_pkg;

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,  // 0 1 2 3
        7'h33, 7'h5B, 7'h5F, 7'h70,  // 4 5 6 7
        7'h7F, 7'h7B, 7'h77, 7'h1F,  // 8 9 A b
        7'h4E, 7'h3D, 7'h4F, 7'h47   // C d E F
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-high seven-segment pattern; polarity is applied by the caller.
module seven_seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = GLYPH[hex];
    end

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed N-digit seven-segment scanner with dead-time, per-digit blanking
// and decimal points. All outputs are registered.
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned SHOW_CYCLES    = 5400,
    parameter int unsigned BLANK_CYCLES   = 600,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_blank,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   en,
    output logic                    frame_tick
);

    localparam int unsigned CntSpanA = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntSpan  = (CntSpanA > 2) ? CntSpanA : 2;
    localparam int unsigned CW       = $clog2(CntSpan);
    localparam int unsigned IW       = $clog2((NUM_DIGITS > 2) ? NUM_DIGITS : 2);

    localparam logic [CW-1:0] ShowLast  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BlankLast = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IdxLast   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SegIdle = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic                  DpIdle  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] EnIdle  = EN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    val_q, val_d;
    logic          blank_q, blank_d;
    logic          dpv_q, dpv_d;
    logic          capture, wrap;

    logic [6:0]            pattern;
    logic [6:0]            seg_d;
    logic                  dp_out_d;
    logic [NUM_DIGITS-1:0] en_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            blank_q <= 1'b1;
            dpv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            blank_q <= blank_d;
            dpv_q   <= dpv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        capture = 1'b0;
        wrap    = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (BLANK_CYCLES == 0 || cnt_q == BlankLast) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    capture = 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == ShowLast) begin
                    cnt_d = '0;
                    wrap  = (idx_q == IdxLast);
                    idx_d = wrap ? '0 : idx_q + 1'b1;
                    // With no dead-time the next digit is captured on this same edge.
                    if (BLANK_CYCLES == 0) begin
                        state_d = SHOW;
                        capture = 1'b1;
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            default: state_d = BLANK;
        endcase

        val_d   = val_q;
        blank_d = blank_q;
        dpv_d   = dpv_q;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IW'(i)) begin
                    val_d   = digits[4*i +: 4];
                    blank_d = digit_blank[i];
                    dpv_d   = dp[i];
                end
            end
        end
    end

    seven_seg_decoder u_decoder (
        .hex     (val_d),
        .pattern (pattern)
    );

    // Outputs are derived from next-state values so the registered pins line up with the state.
    always_comb begin
        seg_d    = SegIdle;
        dp_out_d = DpIdle;
        en_d     = EnIdle;
        if (state_d == SHOW && !blank_d) begin
            seg_d    = SEG_ACTIVE_LOW ? ~pattern : pattern;
            dp_out_d = SEG_ACTIVE_LOW ? ~dpv_d : dpv_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                en_d[i] = (idx_d == IW'(i)) ^ EN_ACTIVE_LOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SegIdle;
            dp_out     <= DpIdle;
            en         <= EnIdle;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp_out     <= dp_out_d;
            en         <= en_d;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed cycle-by-cycle checks of the seven-segment scanner, with and without dead-time.
module tb_seg_mux_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] digits;
    logic [2:0]  digit_blank;
    logic [2:0]  dp;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [2:0] en_a, en_b;
    logic       ft_a, ft_b;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-derived active-low glyphs
    localparam logic [6:0] G7  = 7'b0001111;
    localparam logic [6:0] GA  = 7'b0001000;
    localparam logic [6:0] G2  = 7'b0010010;
    localparam logic [6:0] G3  = 7'b0000110;
    localparam logic [6:0] OFF = 7'h7F;

    always #5 clk = ~clk;

    seg_mux_driver #(
        .NUM_DIGITS(3), .SHOW_CYCLES(4), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .digits(digits), .digit_blank(digit_blank), .dp(dp),
        .seg(seg_a), .dp_out(dp_a), .en(en_a), .frame_tick(ft_a)
    );

    seg_mux_driver #(
        .NUM_DIGITS(3), .SHOW_CYCLES(4), .BLANK_CYCLES(0),
        .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)
    ) dut_nb (
        .clk(clk), .reset(reset), .digits(digits), .digit_blank(digit_blank), .dp(dp),
        .seg(seg_b), .dp_out(dp_b), .en(en_b), .frame_tick(ft_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check n consecutive cycles against one expected output set, then advance.
    task automatic run(input string tag, input bit nb, input logic [2:0] en_e,
                       input logic [6:0] seg_e, input logic dp_e, input logic ft_first,
                       input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, ".en"},  nb ? en_b  : en_a,  en_e);
            check({tag, ".seg"}, nb ? seg_b : seg_a, seg_e);
            check({tag, ".dp"},  nb ? dp_b  : dp_a,  dp_e);
            check({tag, ".ft"},  nb ? ft_b  : ft_a,  (i == 0) ? ft_first : 1'b0);
            step();
        end
    endtask

    initial begin
        reset       = 1'b1;
        digits      = 12'h2A7;
        digit_blank = 3'b000;
        dp          = 3'b000;
        step();
        step();
        check("rst.en",  en_a,  3'b111);
        check("rst.seg", seg_a, OFF);
        check("rst.dp",  dp_a,  1'b1);
        check("rst.ft",  ft_a,  1'b0);
        reset = 1'b0;

        // Frame 1: plain scan order
        run("f1.b0", 0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f1.s0", 0, 3'b110, G7,  1'b1, 1'b0, 4);
        run("f1.b1", 0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f1.s1", 0, 3'b101, GA,  1'b1, 1'b0, 4);
        run("f1.b2", 0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f1.s2", 0, 3'b011, G2,  1'b1, 1'b0, 4);

        // Frame 2: blank digit 1, decimal point on digit 0
        digit_blank = 3'b010;
        dp          = 3'b001;
        run("f2.b0", 0, 3'b111, OFF, 1'b1, 1'b1, 2);
        run("f2.s0", 0, 3'b110, G7,  1'b0, 1'b0, 4);
        run("f2.b1", 0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f2.s1", 0, 3'b111, OFF, 1'b1, 1'b0, 4);
        run("f2.b2", 0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f2.s2", 0, 3'b011, G2,  1'b1, 1'b0, 4);

        // Frame 3: digit 0 changes mid-slot and must not affect the running slot
        run("f3.b0",  0, 3'b111, OFF, 1'b1, 1'b1, 2);
        run("f3.s0a", 0, 3'b110, G7,  1'b0, 1'b0, 2);
        digits = 12'h2A3;
        run("f3.s0b", 0, 3'b110, G7,  1'b0, 1'b0, 2);
        run("f3.b1",  0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f3.s1",  0, 3'b111, OFF, 1'b1, 1'b0, 4);
        run("f3.b2",  0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f3.s2",  0, 3'b011, G2,  1'b1, 1'b0, 4);

        // Frame 4: new digit 0 value, then reset in the middle of digit 1
        digit_blank = 3'b000;
        run("f4.b0", 0, 3'b111, OFF, 1'b1, 1'b1, 2);
        run("f4.s0", 0, 3'b110, G3,  1'b0, 1'b0, 4);
        run("f4.b1", 0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("f4.s1", 0, 3'b101, GA,  1'b1, 1'b0, 2);
        reset = 1'b1;
        step();
        check("mrst.en",  en_a,  3'b111);
        check("mrst.seg", seg_a, OFF);
        check("mrst.ft",  ft_a,  1'b0);
        reset = 1'b0;
        run("r.b0", 0, 3'b111, OFF, 1'b1, 1'b0, 2);
        run("r.s0", 0, 3'b110, G3,  1'b0, 1'b0, 4);
        run("r.b1", 0, 3'b111, OFF, 1'b1, 1'b0, 2);

        // No dead-time: digits back to back, 12-cycle frame
        reset  = 1'b1;
        digits = 12'h2A7;
        dp     = 3'b000;
        step();
        reset = 1'b0;
        run("nb.rst", 1, 3'b111, OFF, 1'b1, 1'b0, 1);
        for (int f = 0; f < 2; f++) begin
            run("nb.s0", 1, 3'b110, G7, 1'b1, (f != 0), 4);
            run("nb.s1", 1, 3'b101, GA, 1'b1, 1'b0, 4);
            run("nb.s2", 1, 3'b011, G2, 1'b1, 1'b0, 4);
        end
        run("nb.s0w", 1, 3'b110, G7, 1'b1, 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
